grain128a_ctrl: RTL and testbench

Sequencer for the grain128a keystream core. It accepts a 128-bit key, a 96-bit IV and a word count through a valid/ready load port. It then drives the core's serial INIT/KEY/IV load protocol. It packs the core's valid keystream bits into WORD_W-bit words and delivers them on a valid/ready output port, gating the core clock enable for backpressure. It sits between the host register/stream interface and one grain128a instance.

---
 rtl/grain128a_ctrl_pkg.sv | 16 +
 rtl/grain128a_ctrl_pack.sv | 57 +++++
 rtl/grain128a_ctrl.sv | 127 ++++++++++++
 tb/tb_grain128a_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grain128a_ctrl_pkg.sv
// Shared state encoding and load-protocol lengths for the grain128a sequencer.
package grain128a_ctrl_pkg;

  localparam int KEY_BITS = 128;
  localparam int IV_BITS  = 96;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    KEYIV = 3'd2,
    KEY   = 3'd3,
    RUN   = 3'd4,
    DRAIN = 3'd5
  } state_t;

endpackage

// File: rtl/grain128a_ctrl_pack.sv
// Keystream bit packer plus one-word holding register with a valid/ready output.
// Bits enter LSB-side, so the first keystream bit of a word ends up in its MSB.
module grain128a_ctrl_pack #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              shift_bit,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              pack_full,
  output logic              issue
);

  localparam int CNT_W = $clog2(WORD_W) + 1;

  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] pack_q;

  assign pack_full = (bit_cnt == CNT_W'(WORD_W));
  assign issue     = en & ~clear & pack_full & (~word_valid | word_ready);

  // A full pack moves into the holding register as soon as that register is free
  // (or is being emptied by a handshake on the same enabled cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q     <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (en) begin
      if (clear) begin
        pack_q     <= '0;
        bit_cnt    <= '0;
        word       <= '0;
        word_valid <= 1'b0;
      end else begin
        if (issue) begin
          word       <= pack_q;
          word_valid <= 1'b1;
          bit_cnt    <= '0;
        end else if (word_valid && word_ready) begin
          word_valid <= 1'b0;
        end
        if (shift_en && !pack_full) begin
          pack_q  <= {pack_q[WORD_W-2:0], shift_bit};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/grain128a_ctrl.sv
// Sequencer for one grain128a core: serial key/IV load, keystream word packing, backpressure.
// Optional build macro GRAIN128A_CTRL_ABORT_EN adds an ABORT_I session-abort input.
module grain128a_ctrl
  import grain128a_ctrl_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                CLK_I,
  input  logic                ARESETN_I,
  input  logic                CLKEN_I,
`ifdef GRAIN128A_CTRL_ABORT_EN
  input  logic                ABORT_I,
`endif
  input  logic                LOAD_VALID_I,
  output logic                LOAD_READY_O,
  input  logic [KEY_BITS-1:0] KEY_I,
  input  logic [IV_BITS-1:0]  IV_I,
  input  logic [LEN_W-1:0]    LEN_I,
  output logic [WORD_W-1:0]   WORD_O,
  output logic                WORD_VALID_O,
  input  logic                WORD_READY_I,
  output logic                BUSY_O,
  output logic                DONE_O,
  output logic                CORE_CLKEN_O,
  output logic                CORE_INIT_O,
  output logic                CORE_KEY_O,
  output logic                CORE_IV_O,
  input  logic                CORE_KS_I,
  input  logic                CORE_KS_VALID_I
);

  state_t              state;
  logic [KEY_BITS-1:0] key_sr;
  logic [IV_BITS-1:0]  iv_sr;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    word_cnt;
  logic [6:0]          bit_idx;
  logic                abort_now;
  logic                pack_full;
  logic                issue;
  logic                done_now;

`ifdef GRAIN128A_CTRL_ABORT_EN
  assign abort_now = CLKEN_I & ABORT_I & (state != IDLE);
`else
  assign abort_now = 1'b0;
`endif

  grain128a_ctrl_pack #(.WORD_W(WORD_W)) u_pack (
    .clk        (CLK_I),
    .rst_n      (ARESETN_I),
    .en         (CLKEN_I),
    .clear      (abort_now),
    .shift_en   ((state == RUN) & CORE_KS_VALID_I),
    .shift_bit  (CORE_KS_I),
    .word_ready (WORD_READY_I),
    .word       (WORD_O),
    .word_valid (WORD_VALID_O),
    .pack_full  (pack_full),
    .issue      (issue)
  );

  // DRAIN finishes on the cycle the last word is taken, or at once if nothing is pending.
  assign done_now     = (state == DRAIN) & CLKEN_I & ~abort_now & (~WORD_VALID_O | WORD_READY_I);
  assign DONE_O       = done_now;
  assign LOAD_READY_O = (state == IDLE);
  assign BUSY_O       = (state != IDLE);
  assign CORE_INIT_O  = (state == INIT);
  assign CORE_KEY_O   = ((state == KEYIV) | (state == KEY)) & key_sr[KEY_BITS-1];
  assign CORE_IV_O    = (state == KEYIV) & iv_sr[IV_BITS-1];

  // The core only runs while its next bit has somewhere to go; pack_full is registered,
  // so the consumer's ready never reaches the core enable combinationally.
  assign CORE_CLKEN_O = CLKEN_I & ~abort_now &
                        ((state == INIT) | (state == KEYIV) | (state == KEY) |
                         ((state == RUN) & ~pack_full));

  always_ff @(posedge CLK_I or negedge ARESETN_I) begin
    if (!ARESETN_I) begin
      state    <= IDLE;
      key_sr   <= '0;
      iv_sr    <= '0;
      len_q    <= '0;
      word_cnt <= '0;
      bit_idx  <= '0;
    end else if (CLKEN_I) begin
      if (abort_now) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (LOAD_VALID_I) begin
              key_sr   <= KEY_I;
              iv_sr    <= IV_I;
              len_q    <= LEN_I;
              word_cnt <= '0;
              bit_idx  <= '0;
              state    <= INIT;
            end
          end
          INIT: state <= KEYIV;
          KEYIV: begin
            key_sr  <= {key_sr[KEY_BITS-2:0], 1'b0};
            iv_sr   <= {iv_sr[IV_BITS-2:0], 1'b0};
            bit_idx <= bit_idx + 7'd1;
            if (bit_idx == 7'd95) state <= KEY;
          end
          KEY: begin
            key_sr  <= {key_sr[KEY_BITS-2:0], 1'b0};
            bit_idx <= bit_idx + 7'd1;
            if (bit_idx == 7'd127) state <= (len_q == '0) ? DRAIN : RUN;
          end
          RUN: begin
            if (issue) begin
              word_cnt <= word_cnt + LEN_W'(1);
              if (word_cnt == len_q - LEN_W'(1)) state <= DRAIN;
            end
          end
          DRAIN: if (done_now) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grain128a_ctrl.sv
// Scoreboard bench for grain128a_ctrl; a small core stand-in checks the serial load and feeds keystream.
`timescale 1ns/1ps
module tb_grain128a_ctrl;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int WARMUP = 24;

  localparam logic [127:0] STREAM_A = 128'hc0207f22_1660650b_6a952ae2_6586136f;
  localparam logic [127:0] STREAM_B = 128'hf88720c1_3f46e6a4_3c07eeed_89161a4d;
  localparam logic [127:0] STREAM_C = 128'h564b3622_19bd90e3_01f259cf_52bf5da9;
  localparam logic [127:0] KEY_B    = 128'h0123456789abcdef123456789abcdef0;
  localparam logic [95:0]  IV_B     = 96'h0123456789abcdef12345678;
  localparam logic [95:0]  IV_C     = 96'h800000000000000000000000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clken = 1'b1;
  logic              load_valid = 1'b0;
  logic [127:0]      key_in = '0;
  logic [95:0]       iv_in = '0;
  logic [LEN_W-1:0]  len_in = '0;
  logic              word_ready = 1'b1;
  logic              abort_drv = 1'b0;
  logic              load_ready, word_valid, busy, done;
  logic              core_clken, core_init, core_key, core_iv;
  logic [WORD_W-1:0] word;
  logic              core_ks;
  logic              core_ks_valid = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [WORD_W-1:0] exp_q[$];
  int popped = 0;
  int done_cnt = 0;
  int init_en_cnt = 0;
  logic gate_mode = 1'b0;
  logic [3:0] lfsr = 4'b1001;

  logic [127:0] cur_key = '0;
  logic [95:0]  cur_iv = '0;
  logic [127:0] cur_stream = '0;
  int stub_phase = 0;
  int stub_idx = 0;
  int stub_warm = 0;
  int ks_idx = 0;
  int load_errs = 0;

  logic              hold_pending = 1'b0;
  logic [WORD_W-1:0] hold_word = '0;

  grain128a_ctrl #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .CLK_I           (clk),
    .ARESETN_I       (rst_n),
    .CLKEN_I         (clken),
`ifdef GRAIN128A_CTRL_ABORT_EN
    .ABORT_I         (abort_drv),
`endif
    .LOAD_VALID_I    (load_valid),
    .LOAD_READY_O    (load_ready),
    .KEY_I           (key_in),
    .IV_I            (iv_in),
    .LEN_I           (len_in),
    .WORD_O          (word),
    .WORD_VALID_O    (word_valid),
    .WORD_READY_I    (word_ready),
    .BUSY_O          (busy),
    .DONE_O          (done),
    .CORE_CLKEN_O    (core_clken),
    .CORE_INIT_O     (core_init),
    .CORE_KEY_O      (core_key),
    .CORE_IV_O       (core_iv),
    .CORE_KS_I       (core_ks),
    .CORE_KS_VALID_I (core_ks_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core stand-in: checks the serial key/IV bits, then after a warm-up streams the
  // session's keystream, advancing one bit per enabled core cycle.
  always @(posedge clk) begin
    if (core_clken) begin
      if (core_init) begin
        stub_phase    <= 1;
        stub_idx      <= 0;
        load_errs     <= 0;
        core_ks_valid <= 1'b0;
      end else begin
        case (stub_phase)
          1: begin
            if (core_key !== cur_key[127-stub_idx] ||
                core_iv !== ((stub_idx < 96) ? cur_iv[95-stub_idx] : 1'b0))
              load_errs <= load_errs + 1;
            if (stub_idx == 127) begin
              stub_phase <= 2;
              stub_warm  <= 0;
            end
            stub_idx <= stub_idx + 1;
          end
          2: begin
            if (stub_warm == WARMUP - 1) begin
              stub_phase    <= 3;
              core_ks_valid <= 1'b1;
              ks_idx        <= 0;
            end else stub_warm <= stub_warm + 1;
          end
          3: ks_idx <= ks_idx + 1;
          default: ;
        endcase
      end
    end
  end

  assign core_ks = (ks_idx < 128) ? cur_stream[127-ks_idx] : 1'b0;

  // Monitor: pops the scoreboard on every word handshake and checks hold stability.
  always @(negedge clk) begin
    logic hs;
    hs = 1'b0;
    if (rst_n) begin
      if (hold_pending && word_valid) checkOutput("word_stable", word, hold_word);
      hold_pending = 1'b0;
      if (clken && !abort_drv) begin
        if (done) done_cnt++;
        if (core_init) init_en_cnt++;
        if (word_valid && word_ready) begin
          hs = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word: got %0h, expected none", word);
          end else begin
            checkOutput("word", word, exp_q.pop_front());
            popped++;
          end
        end
      end
      if (word_valid && !hs) begin
        hold_pending = 1'b1;
        hold_word    = word;
      end
    end else hold_pending = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (gate_mode) begin
      lfsr  = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      clken = lfsr[0];
    end
  endtask

  task automatic applyStimulus(input logic [127:0] key, input logic [95:0] iv,
                               input int len, input logic [127:0] stream);
    bit accepted;
    accepted = 1'b0;
    cur_key = key;
    cur_iv = iv;
    cur_stream = stream;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(stream[127 - 32*i -: 32]);
    popped = 0;
    init_en_cnt = 0;
    key_in = key;
    iv_in = iv;
    len_in = LEN_W'(len);
    load_valid = 1'b1;
    for (int n = 0; n < 2000 && !accepted; n++) begin
      if (load_ready && clken) accepted = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    checkOutput("load_accept", {127'd0, accepted}, 128'd1);
    checkOutput("busy_after_load", {126'd0, busy, load_ready}, 128'b10);
  endtask

  task automatic waitPopped(input int n);
    int cyc;
    cyc = 0;
    while (popped < n && cyc < 5000) begin
      tick();
      cyc++;
    end
    checkOutput("word_arrival", 128'(popped >= n), 128'd1);
  endtask

  task automatic waitDone(input string name);
    int start;
    int cyc;
    start = done_cnt;
    cyc = 0;
    while (done_cnt == start && cyc < 5000) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
    checkOutput({name, "_done_pulses"}, 128'(done_cnt - start), 128'd1);
    checkOutput({name, "_words_left"}, 128'(exp_q.size()), 128'd0);
    checkOutput({name, "_init_cycles"}, 128'(init_en_cnt), 128'd1);
    checkOutput({name, "_load_bits"}, 128'(stub_idx), 128'd128);
    checkOutput({name, "_load_errs"}, 128'(load_errs), 128'd0);
    checkOutput({name, "_idle"}, {126'd0, load_ready, busy}, 128'b10);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_ctrl"},
                {120'd0, load_ready, word_valid, done, busy, core_clken, core_init, core_key, core_iv},
                128'h80);
    checkOutput({name, "_word"}, 128'(word), 128'd0);
  endtask

  initial begin
    #20000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    applyStimulus('0, '0, 4, STREAM_A);
    waitDone("zero_key");

    applyStimulus(KEY_B, IV_B, 4, STREAM_B);
    waitDone("key_iv");

    applyStimulus('0, '0, 4, STREAM_A);
    waitPopped(1);
    word_ready = 1'b0;
    repeat (200) tick();
    checkOutput("stall_core_gated", {126'd0, core_clken, word_valid}, 128'b01);
    checkOutput("stall_bits_taken", 128'(ks_idx), 128'd96);
    word_ready = 1'b1;
    waitDone("backpressure");

    gate_mode = 1'b1;
    applyStimulus('0, IV_C, 4, STREAM_C);
    waitDone("gated");
    gate_mode = 1'b0;
    clken = 1'b1;

    applyStimulus('0, '0, 0, STREAM_A);
    waitDone("len0");
    checkOutput("len0_no_words", 128'(popped), 128'd0);

    applyStimulus('0, '0, 4, STREAM_A);
    waitPopped(1);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("midrun_reset");
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    applyStimulus('0, '0, 4, STREAM_A);
    waitDone("after_reset");

`ifdef GRAIN128A_CTRL_ABORT_EN
    begin
      int d0;
      applyStimulus('0, '0, 4, STREAM_A);
      waitPopped(2);
      d0 = done_cnt;
      abort_drv = 1'b1;
      tick();
      abort_drv = 1'b0;
      checkOutput("abort_state", {125'd0, word_valid, load_ready, busy}, 128'b010);
      repeat (50) tick();
      checkOutput("abort_no_done", 128'(done_cnt - d0), 128'd0);
      checkOutput("abort_core_gated", {127'd0, core_clken}, 128'd0);
      exp_q.delete();
      applyStimulus('0, '0, 4, STREAM_A);
      waitDone("after_abort");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
